// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment controller.
package seven_seg_pkg;

  localparam int unsigned NDigits = 4;
  localparam logic [6:0]  SegOff  = 7'h7F;
  localparam logic [3:0]  AnOff   = 4'hF;
  localparam logic        DpOff   = 1'b1;

  typedef logic [1:0] digit_idx_t;

  function automatic logic [3:0] an_onehot_low(digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex_to_7_seg.sv
// Combinational hex nibble to active-low {g..a} segment pattern.
module hex_to_7_seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    unique case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner_scan_timer.sv
// Digit-slot counter and digit index for the scanner; freezes while en_i is low.
module scan_timer
  import seven_seg_pkg::*;
#(
  parameter int unsigned DigitCycles = 100000,
  parameter int unsigned BlankCycles = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output digit_idx_t idx_o,
  output logic       is_blank_o,
  output logic       slot_last_o,
  output logic       frame_last_o
);

  localparam int unsigned CntW = $clog2(DigitCycles);

  logic [CntW-1:0] cnt_q, cnt_d;
  digit_idx_t      idx_q, idx_d;
  logic            at_end;

  assign at_end = (cnt_q == CntW'(DigitCycles - 1));

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (en_i) begin
      if (at_end) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o        = idx_q;
  assign is_blank_o   = (cnt_q < CntW'(BlankCycles));
  assign slot_last_o  = en_i & at_end;
  assign frame_last_o = en_i & at_end & (idx_q == digit_idx_t'(NDigits - 1));

endmodule

// File: rtl/seven_seg_scanner.sv
// 4-digit common-anode display scanner with shadow-buffered writes committed per frame.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned DigitCycles = 100000,
  parameter int unsigned BlankCycles = 1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        wr_i,
  input  logic [15:0] wr_value_i,
  input  logic [3:0]  wr_dp_i,
  input  logic [3:0]  wr_blank_i,
  output logic        pending_o,
  output logic        frame_done_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o
);

  digit_idx_t idx;
  logic       is_blank, slot_last, frame_last;

  scan_timer #(
    .DigitCycles(DigitCycles),
    .BlankCycles(BlankCycles)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .idx_o       (idx),
    .is_blank_o  (is_blank),
    .slot_last_o (slot_last),
    .frame_last_o(frame_last)
  );

  logic [15:0] sh_value_q, disp_value_q;
  logic [3:0]  sh_dp_q, disp_dp_q, sh_blank_q, disp_blank_q;
  logic        pending_q, pending_d, commit;

  // The pre-write shadow commits even when a write lands on the boundary cycle.
  assign commit    = frame_last & pending_q;
  assign pending_d = wr_i | (pending_q & ~commit);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_value_q   <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= 4'hF;
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= 4'hF;
      pending_q    <= 1'b0;
    end else begin
      if (commit) begin
        disp_value_q <= sh_value_q;
        disp_dp_q    <= sh_dp_q;
        disp_blank_q <= sh_blank_q;
      end
      if (wr_i) begin
        sh_value_q <= wr_value_i;
        sh_dp_q    <= wr_dp_i;
        sh_blank_q <= wr_blank_i;
      end
      pending_q <= pending_d;
    end
  end

  logic [3:0] nibble;
  logic [6:0] seg_dec;

  always_comb begin
    nibble = '0;
    unique case (idx)
      2'd0: nibble = disp_value_q[3:0];
      2'd1: nibble = disp_value_q[7:4];
      2'd2: nibble = disp_value_q[11:8];
      2'd3: nibble = disp_value_q[15:12];
      default: nibble = '0;
    endcase
  end

  hex_to_7_seg u_dec (
    .hex_i(nibble),
    .seg_o(seg_dec)
  );

  logic       lit;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  always_comb begin
    lit   = en_i & ~is_blank & ~disp_blank_q[idx];
    an_d  = AnOff;
    seg_d = SegOff;
    dp_d  = DpOff;
    if (lit) begin
      an_d  = an_onehot_low(idx);
      seg_d = seg_dec;
      dp_d  = ~disp_dp_q[idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_q  <= AnOff;
      seg_q <= SegOff;
      dp_q  <= DpOff;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign pending_o    = pending_q;
  assign frame_done_o = frame_last;

  logic unused_slot_last;
  assign unused_slot_last = slot_last;

endmodule
